// File: rtl/expr_gen.sv
// rtl/expr_gen.sv - serialises a latched BCD operand/operator list as an ASCII expression stream
module expr_gen (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [3:0]  len,
    input  logic [31:0] digits,
    input  logic [6:0]  ops,
    input  logic        ready,
    output logic [7:0]  out,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIGIT = 2'd1;
    localparam logic [1:0] S_OP    = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_len;
    logic [31:0] r_digits;
    logic [7:0]  r_ops;
    logic [2:0]  r_k;
    logic [7:0]  r_out;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_bad_digit;
    logic        w_len_ok;
    logic        w_accept;
    logic        w_xfer;
    logic        w_last;
    logic [2:0]  w_k_next;
    logic [3:0]  w_next_digit;
    logic [7:0]  w_op_char;

    // Only operands inside the requested length are range-checked.
    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((i < int'(len)) && (digits[4*i +: 4] > 4'd9)) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    assign w_len_ok     = (len != 4'd0) && (len <= 4'd8);
    assign w_accept     = w_len_ok && !w_bad_digit;
    assign w_xfer       = r_valid && ready;
    assign w_k_next     = r_k + 3'd1;
    assign w_next_digit = r_digits[{w_k_next, 2'b00} +: 4];
    assign w_op_char    = r_ops[r_k] ? 8'h2A : 8'h2B;
    assign w_last       = ({1'b0, r_k} == (r_len - 4'd1));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_len    <= 4'd0;
            r_digits <= 32'd0;
            r_ops    <= 8'd0;
            r_k      <= 3'd0;
            r_out    <= 8'h00;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_accept) begin
                            r_len    <= len;
                            r_digits <= digits;
                            r_ops    <= {1'b0, ops};
                            r_k      <= 3'd0;
                            r_out    <= 8'h30 + {4'h0, digits[3:0]};
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= S_DIGIT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DIGIT: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_out   <= w_op_char;
                            r_state <= S_OP;
                        end
                    end
                end
                S_OP: begin
                    if (w_xfer) begin
                        r_k     <= w_k_next;
                        r_out   <= 8'h30 + {4'h0, w_next_digit};
                        r_state <= S_DIGIT;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_expr_gen.sv
// tb/tb_expr_gen.sv - vector table, hand sequences and randomized model comparison for expr_gen
module tb_expr_gen;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  len = 4'd0;
    logic [31:0] digits = 32'd0;
    logic [6:0]  ops = 7'd0;
    logic        ready = 1'b0;
    logic [7:0]  out;
    logic        valid;
    logic        busy;
    logic        done;
    logic        err;

    expr_gen dut (
        .clk(clk), .clr(clr), .start(start), .len(len), .digits(digits), .ops(ops),
        .ready(ready), .out(out), .valid(valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [3:0]   len;
        logic [31:0]  digits;
        logic [6:0]   ops;
        int           rmode;
        bit           exp_ok;
        logic [119:0] exp_s;
        int           exp_n;
    } vec_t;

    vec_t vt[8];

    logic [119:0] g_s;
    int g_n, g_dcnt, g_ecnt, g_hviol, g_inv, g_gaps;
    bit g_vseen, g_first, g_timeout;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic void model(input logic [3:0] l, input logic [31:0] d, input logic [6:0] o,
                                  output bit ok, output logic [119:0] s, output int n);
        ok = (l >= 4'd1) && (l <= 4'd8);
        s = '0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(l)) begin
                if (d[4*i +: 4] > 4'd9) ok = 1'b0;
                s = {s[111:0], 8'h30 + {4'h0, d[4*i +: 4]}};
                n++;
                if (i < int'(l) - 1) begin
                    s = {s[111:0], (o[i] ? 8'h2A : 8'h2B)};
                    n++;
                end
            end
        end
        if (!ok) begin
            s = '0;
            n = 0;
        end
    endfunction

    // rmode: 0 ready always high, 1 ready high every third cycle, 2 random ready.
    task automatic run_expr(input logic [3:0] l, input logic [31:0] d, input logic [6:0] o,
                            input int rmode, input bit hold, input bit mutate);
        bit   prev_stall = 1'b0;
        logic [7:0] prev_out = 8'h00;
        int   post = 0;
        bit   finished = 1'b0;
        g_s = '0; g_n = 0; g_dcnt = 0; g_ecnt = 0; g_hviol = 0; g_inv = 0; g_gaps = 0;
        g_vseen = 1'b0; g_first = 1'b0; g_timeout = 1'b0;
        @(negedge clk);
        len = l; digits = d; ops = o; start = 1'b1;
        ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (cyc == 0) g_first = valid;
            if (done) g_dcnt++;
            if (err) g_ecnt++;
            if ((done && err) || ((done || err) && valid) || (done && busy)) g_inv++;
            if (valid) g_vseen = 1'b1;
            if (prev_stall && ((valid !== 1'b1) || (out !== prev_out))) g_hviol++;
            if ((rmode == 0) && (g_n > 0) && (g_dcnt == 0) && !valid) g_gaps++;
            if (mutate && (g_n == 2)) begin
                digits = d ^ 32'h1111_1111;
                ops = ~o;
            end
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = ((cyc % 3) == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (valid && ready) begin
                g_s = {g_s[111:0], out};
                g_n++;
            end
            prev_stall = valid && !ready;
            prev_out = out;
            if ((g_dcnt > 0) || (g_ecnt > 0)) post++;
            if (post > (hold ? 0 : 3)) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) g_timeout = 1'b1;
        if (!hold) start = 1'b0;
    endtask

    task automatic verify(input string tag, input bit exp_ok, input logic [119:0] exp_s, input int exp_n);
        chk({tag, " err_pulses"}, g_ecnt, exp_ok ? 0 : 1);
        chk({tag, " done_pulses"}, g_dcnt, exp_ok ? 1 : 0);
        chk({tag, " first_valid"}, g_first, exp_ok);
        chk({tag, " valid_seen"}, g_vseen, exp_ok);
        chk({tag, " nchars"}, g_n, exp_n);
        chk({tag, " chars"}, g_s, exp_s);
        chk({tag, " hold_stable"}, g_hviol, 0);
        chk({tag, " invariants"}, g_inv, 0);
        chk({tag, " gaps"}, g_gaps, 0);
        chk({tag, " timeout"}, g_timeout, 0);
    endtask

    initial begin
        bit           m_ok;
        logic [119:0] m_s;
        int           m_n;
        logic [3:0]   rl;
        logic [31:0]  rd;
        logic [6:0]   ro;
        int           late_done;

        vt[0] = '{4'd3, 32'h0000_0732, 7'b0000010, 0, 1'b1, "2+3*7", 5};
        vt[1] = '{4'd3, 32'h0000_0732, 7'b0000010, 1, 1'b1, "2+3*7", 5};
        vt[2] = '{4'd1, 32'h0000_0009, 7'b0000000, 0, 1'b1, "9", 1};
        vt[3] = '{4'd0, 32'h0000_0001, 7'b0000000, 0, 1'b0, 120'd0, 0};
        vt[4] = '{4'd2, 32'h0000_00A5, 7'b0000000, 0, 1'b0, 120'd0, 0};
        vt[5] = '{4'd8, 32'h9876_5432, 7'b1010101, 0, 1'b1, "2*3+4*5+6*7+8*9", 15};
        vt[6] = '{4'd9, 32'h1111_1111, 7'b0000000, 0, 1'b0, 120'd0, 0};
        vt[7] = '{4'd7, 32'hF123_4567, 7'b0000000, 2, 1'b1, "7+6+5+4+3+2+1", 13};

        clr = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset outputs", {out, valid, busy, done, err}, 12'h000);
        len = 4'd3; digits = 32'h0000_0732; ops = 7'b0000010; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        chk("clr_priority", {valid, busy, err}, 3'b000);
        clr = 1'b0; start = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_expr(vt[v].len, vt[v].digits, vt[v].ops, vt[v].rmode, 1'b0, 1'b0);
            verify($sformatf("vec%0d", v), vt[v].exp_ok, vt[v].exp_s, vt[v].exp_n);
        end

        // Clear while the third character is presented aborts without done.
        @(negedge clk);
        len = 4'd3; digits = 32'h0000_0732; ops = 7'b0000010; start = 1'b1; ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("clr third char", {valid, out}, {1'b1, 8'h33});
        clr = 1'b1;
        @(negedge clk);
        chk("clr outputs", {out, valid, busy, done, err}, 12'h000);
        clr = 1'b0;
        late_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) late_done++;
        end
        chk("clr no_done", late_done, 0);
        run_expr(4'd2, 32'h0000_0084, 7'b0000001, 0, 1'b0, 1'b0);
        verify("after_clr", 1'b1, "4*8", 3);

        // start held high with inputs changed mid-stream.
        run_expr(4'd3, 32'h0000_0732, 7'b0000010, 0, 1'b1, 1'b1);
        verify("held_start", 1'b1, "2+3*7", 5);
        @(negedge clk);
        chk("held_start idle_gap", {valid, busy}, 2'b00);
        @(negedge clk);
        chk("held_start restart", {valid, busy, out}, {2'b11, 8'h33});
        start = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 40; r++) begin
            rl = 4'($urandom_range(0, 10));
            for (int j = 0; j < 8; j++) begin
                rd[4*j +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            end
            ro = 7'($urandom);
            model(rl, rd, ro, m_ok, m_s, m_n);
            run_expr(rl, rd, ro, 2, 1'b0, 1'b0);
            verify($sformatf("rand%0d", r), m_ok, m_s, m_n);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/expr_gen.md
EXPR_GEN -- requirements
Module: expr_gen

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to emit one expression; sampled only in IDLE.
REQ-005 len  input  4  operand count; legal range 1..8.
REQ-006 digits  input  32  operand i = digits[4i+3:4i] (BCD), i = 0..7; operand 0 is emitted first.
REQ-007 ops  input  7  operator i between operand i and i+1: 0 = '+' (8'h2B), 1 = '*' (8'h2A).
REQ-008 ready  input  1  downstream accepts the current character.
REQ-009 out  output  8  ASCII character; meaningful only while valid=1.
REQ-010 valid  output  1  out holds a character to transfer.
REQ-011 busy  output  1  high from accepted start until the final transfer.
REQ-012 done  output  1  one-cycle pulse after the final character transfers.
REQ-013 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-014 A transfer occurs on a rising edge where valid=1 and ready=1.
REQ-015 States: IDLE, DIGIT (out = operand), OP (out = operator), FIN; there is no error state.
REQ-016 In IDLE with start=1: reject if len=0, len>8, or any operand i<len has a value >9; otherwise accept.
REQ-017 Accept: latch len/digits/ops, go to DIGIT, out=8'h30+operand0, valid=1, busy=1, all on the same edge (1-cycle latency).
REQ-018 Reject: err=1 for one cycle, stay in IDLE, valid/busy stay 0, nothing is latched.
REQ-019 DIGIT, transfer, operand index k < len-1: go to OP, out=operator k, valid stays 1.
REQ-020 OP, transfer: k increments, go to DIGIT, out=8'h30+operand k; back-to-back transfers sustain one character per cycle.
REQ-021 DIGIT, transfer, k = len-1: go to FIN, valid=0, busy=0, done=1 for that one cycle; FIN returns to IDLE on the next edge.
REQ-022 While valid=1 and ready=0: out, valid and state are held unchanged for any number of cycles.
REQ-023 The emitted stream always matches digit(op digit)*, has length 2*len-1 and contains no gaps while ready=1.
REQ-024 In DIGIT, OP and FIN, start is ignored, and changes on len, digits or ops have no effect.
REQ-025 In FIN, start is ignored; a new start is first sampled in IDLE, so the minimum gap between expressions is 1 idle cycle.
REQ-026 The ready input is ignored whenever valid=0.
REQ-027 done and err are never high in the same cycle, and neither is high while valid=1.

Reset
REQ-028 clr=1 at a rising edge forces IDLE, out=8'h00, valid=0, busy=0, done=0, err=0, and clears the index and latched inputs.
REQ-029 clr takes priority over start and ready in the same cycle.
REQ-030 clr mid-expression aborts it with no done pulse; the partial stream is not resumed.
REQ-031 All outputs are registered; power-up values equal the reset values.

Verification
REQ-032 len=3, digits=32'h0000_0732, ops=7'b0000010, start=1, ready=1 -> out 8'h32,8'h2B,8'h33,8'h2A,8'h37 on 5 consecutive cycles, then done=1 for 1 cycle, busy=0.
REQ-033 Same stimulus, ready toggling 1,0,0,1,... -> the same 5 characters in order, each held stable while ready=0, no duplicates or drops.
REQ-034 len=1, digits[3:0]=4'h9 -> a single char 8'h39, then done; len=0, or len=2 with digits[7:4]=4'hA -> err pulse, valid never rises.
REQ-035 clr=1 while the third character is valid -> next cycle all outputs 0, no done; a following start emits the new expression from operand 0.
REQ-036 start held high through an expression with digits changed mid-stream -> the stream reflects the latched values; the next expression starts only after 1 IDLE cycle.
REQ-037 len=8, digits=32'h9876_5432, ops=7'b1010101 -> 15 characters "2*3+4*5+6*7+8*9", then done.
